cm0ik_v6m_rom_table_ahb: RTL
============================

Name: cm0ik_v6m_rom_table_ahb

Overview:
AHB-Lite slave front end for the ARMv6-M CoreSight ROM table in the debug/system address map (4 KB region). Decodes AHB-Lite transfers, pipelines the address phase into the data phase, and returns registered read data from the combinational ROM-table content block. Writes are either read-as-zero/write-ignored or error-responded. Optional wait states support slow integration.

Parameters:
WAIT_STATES, 0, data-phase wait cycles inserted per accepted transfer (0..3).
WRITE_ERR, 1, 1 = writes get a two-cycle ERROR response; 0 = writes complete OKAY and are ignored.

Ports:
hclk  input  1  system clock; all state on rising edge
hreset  input  1  synchronous, active-high reset
hsel  input  1  slave select
haddr  input  32  address; only [11:2] used
htrans  input  2  AHB transfer type; htrans[1]=1 means NONSEQ/SEQ
hwrite  input  1  1 = write
hsize  input  3  ignored; all reads return the full word
hready  input  1  bus-level ready (address phase sampled when high)
hreadyout  output  1  slave ready
hresp  output  1  0 = OKAY, 1 = ERROR
hrdata  output  32  registered read data
jepid  input  7  JEP106 ID, passed to the ROM content block
jepcontinuation  input  4  JEP106 continuation count
partnumber  input  12  part number
revision  input  4  revision
revand  input  4  metal-fix revision
entryzero  input  32  ROM entry 0 base; [31:12] used

Behaviour:
- Reset values: state=IDLE, hreadyout=1, hresp=0, hrdata=0, wait counter=0, captured address/write flag=0. Reset mid-transfer abandons the transfer. No response completes.
- accept = hsel & htrans[1] & hready. Non-accepted cycles (IDLE/BUSY/unselected) give an OKAY response with zero wait states.
- States:
  - IDLE: OKAY, hreadyout=1.
  - WAIT: hreadyout=0, hresp=0.
  - ERR1: hreadyout=0, hresp=1.
  - ERR2: hreadyout=1, hresp=1.
- On accept:
  - Capture addr_q=haddr[11:2] and write_q=hwrite, and load cnt=WAIT_STATES.
  - Write with WRITE_ERR=1: go to WAIT if WAIT_STATES>0, otherwise ERR1.
  - Any other transfer: go to WAIT if WAIT_STATES>0, otherwise stay in IDLE (the data phase completes next cycle).
- WAIT:
  - cnt decrements each cycle.
  - When cnt==1, exit to ERR1 for an errored write, otherwise to IDLE.
  - Exactly WAIT_STATES cycles have hreadyout=0 before completion.
- ERR1 always goes to ERR2. ERR2 behaves as IDLE for accept; a transfer presented during ERR2 is accepted normally.
- ROM address:
  - WAIT_STATES==0: ROM block address = {haddr[11:2],2'b00}.
  - Otherwise: ROM block address = {addr_q,2'b00}.
- hrdata load:
  - WAIT_STATES==0: loaded with ROM output on an accepted read.
  - WAIT_STATES>0: loaded on the last WAIT cycle of a read.
  - Cleared to 0 on any accepted write or non-read completion.
  - Holds otherwise.
- Read data is valid in the completing data-phase cycle (hreadyout=1). Back-to-back reads sustain one word per cycle with WAIT_STATES=0.
- Address bits [31:12] and [1:0] are ignored. Unmapped offsets read 0 (end-of-table marker).
- Writes never alter any state except hrdata clear and the response FSM.

Decomposition:
- Shared package cm0ik_rom_pkg holds:
  - state enum (IDLE, WAIT, ERR1, ERR2);
  - HTRANS encodings (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11);
  - HRESP OKAY/ERROR constants.
- One sub-module: the combinational ROM-table content decoder cm0ik_v6m_rom_table, instantiated once and fed by the ROM address mux.

Test Plan:
- Reset, then read of 0xFF0, then 0xFF4, 0xFF8, 0xFFC (WAIT_STATES=0), back-to-back NONSEQ → hrdata 0x0D, 0x10, 0x05, 0xB1 in consecutive cycles; hreadyout held 1; hresp 0.
- jepid=0x3B, jepcontinuation=4, partnumber=0x4C2, revision=0, revand=0; read 0xFE0/0xFE4/0xFE8/0xFD0 → 0xC2, 0xB4, 0x0B, 0x04.
- entryzero=0xE00FF000; read haddr=0xF00FF000, then 0x...0FCC, then 0x...0004 → 0xE00FF003, 0x00000001, 0x00000000.
- WRITE_ERR=1 write to 0x000 → first data cycle hreadyout=0/hresp=1, second cycle hreadyout=1/hresp=1. Subsequent read of 0xFF0 → 0x0D. WRITE_ERR=0 → single-cycle OKAY, hrdata 0.
- WAIT_STATES=2 read 0xFF4 → hreadyout low exactly 2 cycles, then high with hrdata=0x10. A new NONSEQ held during the waits is accepted only at the completing cycle.
- hreset asserted during WAIT (WAIT_STATES=3) → next cycle hreadyout=1, hresp=0, hrdata=0. Following read completes with correct data.

Source files
------------

// File: rtl/cm0ik_rom_pkg.sv
// Shared types and bus encodings for the ARMv6-M ROM table AHB-Lite slave.
package cm0ik_rom_pkg;

   localparam int unsigned HADDR_W = 32;
   localparam int unsigned HDATA_W = 32;
   localparam int unsigned ROM_AW  = 12;
   localparam int unsigned WORD_AW = 10;

   // Response FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ERR1 = 2'd2,
      ERR2 = 2'd3
   } state_t;

   // HTRANS encodings
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   // HRESP encodings
   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   // Address-phase information carried into the data phase
   typedef struct packed {
      logic [WORD_AW-1:0] addr;
      logic               write;
   } aphase_t;

endpackage

// File: rtl/cm0ik_v6m_rom_table_ahb_if.sv
// AHB-Lite slave-port signal bundle for the ROM table.
interface cm0ik_v6m_rom_table_ahb_if;
   import cm0ik_rom_pkg::*;

   logic               hsel;
   logic [HADDR_W-1:0] haddr;
   logic [1:0]         htrans;
   logic               hwrite;
   logic [2:0]         hsize;
   logic               hready;
   logic               hreadyout;
   logic               hresp;
   logic [HDATA_W-1:0] hrdata;

   modport master (
      output hsel, haddr, htrans, hwrite, hsize, hready,
      input  hreadyout, hresp, hrdata
   );

   modport slave (
      input  hsel, haddr, htrans, hwrite, hsize, hready,
      output hreadyout, hresp, hrdata
   );

endinterface

// File: rtl/cm0ik_v6m_rom_table.sv
// Combinational CoreSight ROM-table contents for the ARMv6-M debug map.
module cm0ik_v6m_rom_table
   import cm0ik_rom_pkg::*;
(
   input  logic [ROM_AW-1:0]  addr,
   input  logic [6:0]         jepid,
   input  logic [3:0]         jepcontinuation,
   input  logic [11:0]        partnumber,
   input  logic [3:0]         revision,
   input  logic [3:0]         revand,
   input  logic [31:0]        entryzero,
   output logic [HDATA_W-1:0] rdata_c
);

   logic unused_c;

   // Byte lanes and the low entry bits are never part of the returned word
   assign unused_c = ^{addr[1:0], entryzero[11:0]};

   // Word-offset decode; anything unmapped reads as the end-of-table marker
   always_comb begin
      rdata_c = '0;
      case (addr[ROM_AW-1:2])
         10'h000: rdata_c = {entryzero[31:12], 12'h003};
         10'h3F3: rdata_c = 32'h0000_0001;
         10'h3F4: rdata_c = {24'h0, 4'h0, jepcontinuation};
         10'h3F8: rdata_c = {24'h0, partnumber[7:0]};
         10'h3F9: rdata_c = {24'h0, jepid[3:0], partnumber[11:8]};
         10'h3FA: rdata_c = {24'h0, revision, 1'b1, jepid[6:4]};
         10'h3FB: rdata_c = {24'h0, revand, 4'h0};
         10'h3FC: rdata_c = 32'h0000_000D;
         10'h3FD: rdata_c = 32'h0000_0010;
         10'h3FE: rdata_c = 32'h0000_0005;
         10'h3FF: rdata_c = 32'h0000_00B1;
         default: rdata_c = '0;
      endcase
   end

endmodule

// File: rtl/cm0ik_v6m_rom_table_ahb.sv
// AHB-Lite slave front end for the ROM table: address/data pipelining,
// optional wait states and write response handling.
module cm0ik_v6m_rom_table_ahb
   import cm0ik_rom_pkg::*;
#(
   parameter int unsigned WAIT_STATES = 0,
   parameter bit          WRITE_ERR   = 1'b1
) (
   input  logic                            hclk,
   input  logic                            hreset,
   cm0ik_v6m_rom_table_ahb_if.slave        ahb,
   input  logic [6:0]                      jepid,
   input  logic [3:0]                      jepcontinuation,
   input  logic [11:0]                     partnumber,
   input  logic [3:0]                      revision,
   input  logic [3:0]                      revand,
   input  logic [31:0]                     entryzero
);

   localparam int unsigned    CNT_W    = 2;
   localparam logic [CNT_W-1:0] WS_INIT = CNT_W'(WAIT_STATES);
   localparam bit             HAS_WAIT = (WAIT_STATES != 0);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   aphase_t            aph_q, aph_d;
   logic [HDATA_W-1:0] hrdata_q, hrdata_d;
   logic               hreadyout_q, hreadyout_d;
   logic               hresp_q, hresp_d;
   logic               take_c;
   logic               last_wait_c;
   logic [ROM_AW-1:0]  rom_addr_c;
   logic [HDATA_W-1:0] rom_data_c;
   logic               unused_c;

   // Only IDLE and ERR2 can start a new data phase
   assign take_c      = ahb.hsel & ahb.htrans[1] & ahb.hready &
                        ((state_q == IDLE) | (state_q == ERR2));
   assign last_wait_c = (state_q == WAIT) & (cnt_q == CNT_W'(1));
   assign unused_c    = ^{ahb.haddr[31:12], ahb.haddr[1:0], ahb.htrans[0], ahb.hsize};

   // Zero-wait reads look up the live address; waited reads use the captured one
   assign rom_addr_c = HAS_WAIT ? {aph_q.addr, 2'b00} : {ahb.haddr[11:2], 2'b00};

   cm0ik_v6m_rom_table u_rom (
      .addr            (rom_addr_c),
      .jepid           (jepid),
      .jepcontinuation (jepcontinuation),
      .partnumber      (partnumber),
      .revision        (revision),
      .revand          (revand),
      .entryzero       (entryzero),
      .rdata_c         (rom_data_c)
   );

   // State register
   always_ff @(posedge hclk) begin
      if (hreset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, ERR2: begin
            state_d = IDLE;
            if (take_c) begin
               if (HAS_WAIT)                      state_d = WAIT;
               else if (ahb.hwrite && WRITE_ERR)  state_d = ERR1;
            end
         end
         WAIT: begin
            if (last_wait_c) state_d = (aph_q.write && WRITE_ERR) ? ERR1 : IDLE;
         end
         ERR1:    state_d = ERR2;
         default: state_d = IDLE;
      endcase
   end

   // Output and datapath next values
   always_comb begin
      cnt_d       = cnt_q;
      aph_d       = aph_q;
      hrdata_d    = hrdata_q;
      hreadyout_d = (state_d == IDLE) || (state_d == ERR2);
      hresp_d     = ((state_d == ERR1) || (state_d == ERR2)) ? HRESP_ERROR : HRESP_OKAY;
      if (take_c) begin
         cnt_d       = WS_INIT;
         aph_d.addr  = ahb.haddr[11:2];
         aph_d.write = ahb.hwrite;
         if (ahb.hwrite)     hrdata_d = '0;
         else if (!HAS_WAIT) hrdata_d = rom_data_c;
      end else if (state_q == WAIT) begin
         cnt_d = cnt_q - CNT_W'(1);
         if (last_wait_c) hrdata_d = aph_q.write ? '0 : rom_data_c;
      end
   end

   // Output and datapath registers
   always_ff @(posedge hclk) begin
      if (hreset) begin
         cnt_q       <= '0;
         aph_q       <= '0;
         hrdata_q    <= '0;
         hreadyout_q <= 1'b1;
         hresp_q     <= HRESP_OKAY;
      end else begin
         cnt_q       <= cnt_d;
         aph_q       <= aph_d;
         hrdata_q    <= hrdata_d;
         hreadyout_q <= hreadyout_d;
         hresp_q     <= hresp_d;
      end
   end

   assign ahb.hreadyout = hreadyout_q;
   assign ahb.hresp     = hresp_q;
   assign ahb.hrdata    = hrdata_q;

endmodule
